astro_unidade_controle: RTL and testbench

Control unit for the AstroGenius memory game. It is a Moore FSM that sequences the game datapath: clearing counters, showing the first stored LED, waiting for and checking each player move, and detecting timeouts. It also handles appending the player's new move to memory at the end of each round and reporting win, loss or timeout. It sits directly upstream of the datapath: its outputs drive the datapath's control inputs, and it consumes the datapath's status flags.

---
 rtl/astro_unidade_controle_pkg.sv | 28 ++
 rtl/astro_unidade_controle.sv | 132 +++++++++++++
 tb/tb_astro_unidade_controle.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/astro_unidade_controle_pkg.sv
// State encoding for the AstroGenius control unit.
// The codes are fixed because db_estado exposes them to the display and to the benches.
package astro_unidade_controle_pkg;

    typedef enum logic [3:0] {
        INICIAL          = 4'h0,
        PREPARACAO       = 4'h1,
        MOSTRA_LED       = 4'h2,
        INICIO_RODADA    = 4'h3,
        ESPERA_JOGADA    = 4'h4,
        REGISTRA         = 4'h5,
        COMPARA          = 4'h6,
        PROXIMA_JOGADA   = 4'h7,
        PREPARA_ESCRITA  = 4'h8,
        ESPERA_ESCRITA   = 4'h9,
        REGISTRA_ESCRITA = 4'hA,
        ESCREVE          = 4'hB,
        PROXIMA_RODADA   = 4'hC,
        FIM_ACERTOU      = 4'hD,
        FIM_ERROU        = 4'hE,
        FIM_TIMEOUT      = 4'hF
    } estado_t;

    function automatic logic eh_final(input estado_t e);
        return (e == FIM_ACERTOU) || (e == FIM_ERROU) || (e == FIM_TIMEOUT);
    endfunction

endpackage

// File: rtl/astro_unidade_controle.sv
// Moore control FSM for the AstroGenius memory game: sequences counters, timers,
// move register and memory write; every output is decoded from the state register.
module astro_unidade_controle
    import astro_unidade_controle_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       jogada_igual,
    input  logic       fim_rodada,
    input  logic       fim_jogo,
    input  logic       fim_mostra_led,
    input  logic       inativo,
    output logic       zera_jogada,
    output logic       conta_jogada,
    output logic       zera_rodada,
    output logic       conta_rodada,
    output logic       zeraR,
    output logic       registraR,
    output logic       zeraInativo,
    output logic       contaInativo,
    output logic       zera_mostra_led,
    output logic       conta_mostra_led,
    output logic       ramWE,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic       timeout,
    output logic [3:0] db_estado
);

    estado_t r_estado;
    estado_t w_proximo;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_estado <= INICIAL;
        else       r_estado <= w_proximo;
    end

    always_comb begin
        w_proximo = r_estado;
        case (r_estado)
            INICIAL:          if (iniciar) w_proximo = PREPARACAO;
            PREPARACAO:       w_proximo = MOSTRA_LED;
            MOSTRA_LED:       if (fim_mostra_led) w_proximo = INICIO_RODADA;
            INICIO_RODADA:    w_proximo = ESPERA_JOGADA;
            // a move arriving together with the timeout still counts
            ESPERA_JOGADA: begin
                if (jogada_feita)  w_proximo = REGISTRA;
                else if (inativo)  w_proximo = FIM_TIMEOUT;
            end
            REGISTRA:         w_proximo = COMPARA;
            COMPARA: begin
                if (!jogada_igual)    w_proximo = FIM_ERROU;
                else if (!fim_rodada) w_proximo = PROXIMA_JOGADA;
                else if (fim_jogo)    w_proximo = FIM_ACERTOU;
                else                  w_proximo = PREPARA_ESCRITA;
            end
            PROXIMA_JOGADA:   w_proximo = ESPERA_JOGADA;
            PREPARA_ESCRITA:  w_proximo = ESPERA_ESCRITA;
            ESPERA_ESCRITA: begin
                if (jogada_feita)  w_proximo = REGISTRA_ESCRITA;
                else if (inativo)  w_proximo = FIM_TIMEOUT;
            end
            REGISTRA_ESCRITA: w_proximo = ESCREVE;
            ESCREVE:          w_proximo = PROXIMA_RODADA;
            PROXIMA_RODADA:   w_proximo = MOSTRA_LED;
            FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT:
                              if (iniciar) w_proximo = PREPARACAO;
            default:          w_proximo = INICIAL;
        endcase
    end

    always_comb begin
        zera_jogada      = 1'b0;
        conta_jogada     = 1'b0;
        zera_rodada      = 1'b0;
        conta_rodada     = 1'b0;
        zeraR            = 1'b0;
        registraR        = 1'b0;
        zeraInativo      = 1'b0;
        contaInativo     = 1'b0;
        zera_mostra_led  = 1'b0;
        conta_mostra_led = 1'b0;
        ramWE            = 1'b0;
        ganhou           = 1'b0;
        perdeu           = 1'b0;
        timeout          = 1'b0;
        case (r_estado)
            PREPARACAO: begin
                zera_jogada     = 1'b1;
                zera_rodada     = 1'b1;
                zeraR           = 1'b1;
                zeraInativo     = 1'b1;
                zera_mostra_led = 1'b1;
            end
            MOSTRA_LED:       conta_mostra_led = 1'b1;
            INICIO_RODADA: begin
                zera_jogada     = 1'b1;
                zeraInativo     = 1'b1;
                zera_mostra_led = 1'b1;
            end
            ESPERA_JOGADA,
            ESPERA_ESCRITA:   contaInativo = 1'b1;
            REGISTRA,
            REGISTRA_ESCRITA: begin
                registraR   = 1'b1;
                zeraInativo = 1'b1;
            end
            PROXIMA_JOGADA:   conta_jogada = 1'b1;
            // clearing the inactivity timer here gives the new move a full window
            PREPARA_ESCRITA: begin
                conta_jogada = 1'b1;
                zeraInativo  = 1'b1;
            end
            ESCREVE:          ramWE = 1'b1;
            PROXIMA_RODADA: begin
                conta_rodada = 1'b1;
                zeraR        = 1'b1;
            end
            FIM_ACERTOU:      ganhou  = 1'b1;
            FIM_ERROU:        perdeu  = 1'b1;
            FIM_TIMEOUT:      timeout = 1'b1;
            default: ;
        endcase
    end

    assign pronto    = eh_final(r_estado);
    assign db_estado = r_estado;

endmodule

// File: tb/tb_astro_unidade_controle.sv
// Bench for astro_unidade_controle: directed game scenarios followed by random
// input traffic checked against a behavioural model of the game sequencing.
module tb_astro_unidade_controle;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0, jogada_feita = 1'b0, jogada_igual = 1'b0;
    logic       fim_rodada = 1'b0, fim_jogo = 1'b0, fim_mostra_led = 1'b0, inativo = 1'b0;
    logic       zera_jogada, conta_jogada, zera_rodada, conta_rodada, zeraR, registraR;
    logic       zeraInativo, contaInativo, zera_mostra_led, conta_mostra_led;
    logic       ramWE, pronto, ganhou, perdeu, timeout;
    logic [3:0] db_estado;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] exp_estado = 4'h0;

    localparam logic [6:0] INI = 7'h40, JF = 7'h20, JI = 7'h10, FR = 7'h08,
                           FJ = 7'h04, FML = 7'h02, INA = 7'h01, NADA = 7'h00;

    astro_unidade_controle dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
        .jogada_igual(jogada_igual), .fim_rodada(fim_rodada), .fim_jogo(fim_jogo),
        .fim_mostra_led(fim_mostra_led), .inativo(inativo),
        .zera_jogada(zera_jogada), .conta_jogada(conta_jogada),
        .zera_rodada(zera_rodada), .conta_rodada(conta_rodada),
        .zeraR(zeraR), .registraR(registraR),
        .zeraInativo(zeraInativo), .contaInativo(contaInativo),
        .zera_mostra_led(zera_mostra_led), .conta_mostra_led(conta_mostra_led),
        .ramWE(ramWE), .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu),
        .timeout(timeout), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // {zj, cj, zr, cr, zR, rR, zI, cI, zm, cm, we, pronto, ganhou, perdeu, timeout}
    logic [14:0] w_obs;
    assign w_obs = {zera_jogada, conta_jogada, zera_rodada, conta_rodada, zeraR, registraR,
                    zeraInativo, contaInativo, zera_mostra_led, conta_mostra_led,
                    ramWE, pronto, ganhou, perdeu, timeout};

    function automatic logic [14:0] saidas(input logic [3:0] e);
        logic [14:0] t [16];
        t[0]  = 15'b000000000000000;
        t[1]  = 15'b101010101000000;
        t[2]  = 15'b000000000100000;
        t[3]  = 15'b100000101000000;
        t[4]  = 15'b000000010000000;
        t[5]  = 15'b000001100000000;
        t[6]  = 15'b000000000000000;
        t[7]  = 15'b010000000000000;
        t[8]  = 15'b010000100000000;
        t[9]  = 15'b000000010000000;
        t[10] = 15'b000001100000000;
        t[11] = 15'b000000000010000;
        t[12] = 15'b000110000000000;
        t[13] = 15'b000000000001100;
        t[14] = 15'b000000000001010;
        t[15] = 15'b000000000001001;
        return t[e];
    endfunction

    // Game-level model: waits advance by one on a move, linear steps advance by one.
    function automatic logic [3:0] modelo(input logic [3:0] s, input logic [6:0] in);
        logic ini, jf, ji, fr, fj, fml, ina;
        {ini, jf, ji, fr, fj, fml, ina} = in;
        if (s == 4'd0)                return ini ? 4'd1 : 4'd0;
        if (s >= 4'd13)               return ini ? 4'd1 : s;
        if (s == 4'd4 || s == 4'd9)   return jf ? s + 4'd1 : (ina ? 4'd15 : s);
        if (s == 4'd2)                return fml ? 4'd3 : 4'd2;
        if (s == 4'd6)                return !ji ? 4'd14 : (!fr ? 4'd7 : (fj ? 4'd13 : 4'd8));
        if (s == 4'd7)                return 4'd4;
        if (s == 4'd12)               return 4'd2;
        return s + 4'd1;
    endfunction

    task automatic aplica(input logic [6:0] in);
        {iniciar, jogada_feita, jogada_igual, fim_rodada, fim_jogo, fim_mostra_led, inativo} = in;
    endtask

    task automatic confere(input string tag, input logic [3:0] esp);
        n_cmp++;
        assert (db_estado === esp) else begin
            n_err++;
            $error("FAIL %s estado obs=%h esp=%h", tag, db_estado, esp);
        end
        n_cmp++;
        assert (w_obs === saidas(esp)) else begin
            n_err++;
            $error("FAIL %s saidas obs=%b esp=%b", tag, w_obs, saidas(esp));
        end
    endtask

    task automatic passo(input string tag, input logic [6:0] in, input logic [3:0] esp);
        @(negedge clock);
        aplica(in);
        @(posedge clock);
        #1;
        exp_estado = esp;
        confere(tag, esp);
    endtask

    task automatic reset_assinc(input string tag);
        @(negedge clock);
        aplica(NADA);
        reset = 1'b1;
        #1;
        exp_estado = 4'd0;
        confere(tag, 4'd0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    int n_we;
    int n_rodadas;

    initial begin
        #2;
        confere("reset_ini", 4'd0);
        @(negedge clock);
        reset = 1'b0;

        passo("ini_prep",   INI,          4'h1);
        passo("prep_mostra", NADA,        4'h2);
        passo("mostra_fim", FML,          4'h3);
        passo("inicio_esp", NADA,         4'h4);
        passo("jog_reg",    JF | JI | FR, 4'h5);
        passo("reg_comp",   JI | FR,      4'h6);
        passo("comp_prep",  JI | FR,      4'h8);
        passo("prep_escr",  NADA,         4'h9);
        passo("escr_reg",   JF,           4'hA);
        passo("reg_escreve", NADA,        4'hB);
        passo("escreve_prox", NADA,       4'hC);
        passo("prox_mostra", NADA,        4'h2);
        passo("mostra_fim2", FML,         4'h3);
        passo("inicio2",    NADA,         4'h4);
        passo("errou_reg",  JF,           4'h5);
        passo("errou_comp", NADA,         4'h6);
        passo("errou",      FR,           4'hE);
        passo("errou_fica", NADA,         4'hE);
        passo("errou_ini",  INI,          4'h1);
        passo("r_mostra",   NADA,         4'h2);
        passo("espurio",    JF,           4'h2);
        passo("r_inicio",   FML,          4'h3);
        passo("r_espera",   NADA,         4'h4);
        passo("jog_e_inat", JF | INA,     4'h5);
        passo("meio_comp",  NADA,         4'h6);
        passo("meio_prox",  JI,           4'h7);
        passo("meio_esp",   NADA,         4'h4);
        passo("esp_fica",   NADA,         4'h4);
        passo("timeout4",   INA,          4'hF);
        passo("to_ini",     INI,          4'h1);
        passo("v_mostra",   NADA,         4'h2);
        passo("v_inicio",   FML,          4'h3);
        passo("v_esp",      NADA,         4'h4);
        passo("v_reg",      JF,           4'h5);
        passo("v_comp",     NADA,         4'h6);
        passo("ganhou",     JI | FR | FJ, 4'hD);
        passo("ganhou_rei", INI,          4'h1);
        passo("t_mostra",   NADA,         4'h2);
        passo("t_inicio",   FML,          4'h3);
        passo("t_esp",      NADA,         4'h4);
        passo("t_reg",      JF,           4'h5);
        passo("t_comp",     JI | FR,      4'h6);
        reset_assinc("reset_em_compara");
        passo("pos_reset",  INI,          4'h1);
        passo("t2_mostra",  NADA,         4'h2);
        passo("t2_inicio",  FML,          4'h3);
        passo("t2_esp",     NADA,         4'h4);
        passo("t2_reg",     JF,           4'h5);
        passo("t2_comp",    NADA,         4'h6);
        passo("t2_prep",    JI | FR,      4'h8);
        passo("t2_escr",    NADA,         4'h9);
        passo("timeout9",   INA,          4'hF);
        passo("t3_ini",     INI,          4'h1);
        passo("t3_mostra",  NADA,         4'h2);
        passo("t3_inicio",  FML,          4'h3);
        passo("t3_esp",     NADA,         4'h4);
        passo("t3_reg",     JF,           4'h5);
        passo("t3_comp",    NADA,         4'h6);
        passo("t3_prep",    JI | FR,      4'h8);
        passo("t3_escr",    NADA,         4'h9);
        passo("t3_regesc",  JF,           4'hA);
        passo("t3_escreve", NADA,         4'hB);
        reset_assinc("reset_em_escreve");

        // Random traffic: every completed round must carry exactly one write cycle.
        n_we = 0;
        n_rodadas = 0;
        for (int c = 0; c < 3000; c++) begin
            logic [6:0] in;
            logic [3:0] prox;
            if ($urandom_range(0, 299) == 0) begin
                reset_assinc("rand_reset");
                n_we = 0;
                continue;
            end
            in[6] = ($urandom_range(0, 9) < 2);
            in[5] = ($urandom_range(0, 9) < 3);
            in[4] = ($urandom_range(0, 9) < 8);
            in[3] = ($urandom_range(0, 9) < 5);
            in[2] = ($urandom_range(0, 9) < 2);
            in[1] = ($urandom_range(0, 9) < 4);
            in[0] = ($urandom_range(0, 19) < 1);
            prox = modelo(exp_estado, in);
            passo("rand", in, prox);
            if (ramWE === 1'b1) n_we++;
            if (exp_estado == 4'd12) begin
                n_rodadas++;
                n_cmp++;
                assert (n_we === 1) else begin
                    n_err++;
                    $error("FAIL rand_we_por_rodada obs=%0d esp=1", n_we);
                end
                n_we = 0;
            end
            if (exp_estado == 4'd1) n_we = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
